tdc_therm_encoder: RTL and testbench

TDC_THERM_ENCODER -- requirements
Module: tdc_therm_encoder

---
 rtl/tdc_therm_encoder.sv | 101 ++++++++++
 tb/tb_tdc_therm_encoder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/tdc_therm_encoder.sv
// Carry-chain TDC thermometer-to-binary encoder: two-flop capture, 3-tap
// majority bubble correction, popcount, and a single output register that drops results under back-pressure.

module tdc_maj3 (
    input  logic lo,
    input  logic mid,
    input  logic hi,
    output logic maj
);
    assign maj = (lo & mid) | (lo & hi) | (mid & hi);
endmodule

module tdc_therm_encoder #(
    parameter int TAPS   = 64,
    parameter int CODE_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TAPS-1:0]   tap_i,
    input  logic              sample_i,
    output logic [CODE_W-1:0] code_o,
    output logic              sat_o,
    output logic              zero_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              drop_o,
    output logic [7:0]        drop_cnt_o
);
    localparam int STAGES = 2;

    logic [STAGES:0]   vld_pipe;
    logic [TAPS-1:0]   s1_tap, s2_tap, s3_bits;
    logic [TAPS+1:0]   ext;
    logic [TAPS-1:0]   bub;
    logic [CODE_W-1:0] cnt;
    logic              load, drop;

    // Chain boundaries: below tap 0 reads as already-propagated, above the top as not reached.
    assign ext = {1'b0, s2_tap, 1'b1};

    genvar g;
    generate
        for (g = 0; g < TAPS; g++) begin : g_lane
            tdc_maj3 u_maj (
                .lo  (ext[g]),
                .mid (ext[g+1]),
                .hi  (ext[g+2]),
                .maj (bub[g])
            );
        end
    endgenerate

    always_comb begin
        cnt = '0;
        for (int i = 0; i < TAPS; i++)
            cnt = cnt + CODE_W'(s3_bits[i]);
    end

    // The popcount stage doubles as the output register, so a new result
    // only loads when the held one is gone or leaving on this edge.
    assign load = vld_pipe[STAGES] && (!valid_o || ready_i);
    assign drop = vld_pipe[STAGES] && valid_o && !ready_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_tap   <= '0;
            s2_tap   <= '0;
            s3_bits  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], sample_i};
            s1_tap   <= tap_i;
            s2_tap   <= s1_tap;
            if (vld_pipe[1])
                s3_bits <= bub;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_o     <= '0;
            sat_o      <= 1'b0;
            zero_o     <= 1'b0;
            valid_o    <= 1'b0;
            drop_o     <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            drop_o <= drop;
            if (drop && drop_cnt_o != 8'hFF)
                drop_cnt_o <= drop_cnt_o + 8'd1;
            if (load) begin
                code_o  <= cnt;
                sat_o   <= (cnt == CODE_W'(TAPS));
                zero_o  <= (cnt == '0);
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tdc_therm_encoder.sv
// Directed bench for tdc_therm_encoder (TAPS=64): vector table plus hand-written
// back-to-back, back-pressure, reset and drop-saturation sequences.

module tb_tdc_therm_encoder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] tap_i;
    logic        sample_i;
    logic [6:0]  code_o;
    logic        sat_o, zero_o, valid_o, ready_i, drop_o;
    logic [7:0]  drop_cnt_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [63:0] tap;
        logic [6:0]  code;
        logic        sat;
        logic        zero;
    } vec_t;

    vec_t vecs[8];

    tdc_therm_encoder #(.TAPS(64), .CODE_W(7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tap_i      (tap_i),
        .sample_i   (sample_i),
        .code_o     (code_o),
        .sat_o      (sat_o),
        .zero_o     (zero_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .drop_o     (drop_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else
            pass_cnt++;
    endtask

    // Strobe one capture, scramble tap_i afterwards, and check exact latency and one-cycle valid.
    task automatic run_vec(input int idx, input vec_t v);
        tap_i = v.tap; sample_i = 1'b1;
        tick();
        sample_i = 1'b0; tap_i = ~v.tap;
        tick();
        tick();
        check($sformatf("v%0d_early", idx), {63'd0, valid_o}, 64'd0);
        tick();
        check($sformatf("v%0d_valid", idx), {63'd0, valid_o}, 64'd1);
        check($sformatf("v%0d_code", idx), {57'd0, code_o}, {57'd0, v.code});
        check($sformatf("v%0d_sat", idx), {63'd0, sat_o}, {63'd0, v.sat});
        check($sformatf("v%0d_zero", idx), {63'd0, zero_o}, {63'd0, v.zero});
        tick();
        check($sformatf("v%0d_once", idx), {63'd0, valid_o}, 64'd0);
    endtask

    initial begin
        logic seen;
        vecs[0] = '{64'h0000_0000_0000_FFFF, 7'd16, 1'b0, 1'b0};
        vecs[1] = '{64'h0000_0100_0000_FFEF, 7'd16, 1'b0, 1'b0};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 1'b1, 1'b0};
        vecs[3] = '{64'h0000_0000_0000_0000, 7'd0,  1'b0, 1'b1};
        vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 7'd63, 1'b0, 1'b0};
        vecs[5] = '{64'h0000_0000_0000_0002, 7'd1,  1'b0, 1'b0};
        vecs[6] = '{64'h8000_0000_0000_0000, 7'd0,  1'b0, 1'b1};
        vecs[7] = '{64'h0000_0000_0000_00FF, 7'd8,  1'b0, 1'b0};

        rst_n = 1'b0; tap_i = '1; sample_i = 1'b1; ready_i = 1'b1;
        tick(); tick(); tick();
        check("rst_valid", {63'd0, valid_o}, 64'd0);
        check("rst_code", {57'd0, code_o}, 64'd0);
        check("rst_flags", {61'd0, sat_o, zero_o, drop_o}, 64'd0);
        check("rst_dcnt", {56'd0, drop_cnt_o}, 64'd0);
        rst_n = 1'b1; sample_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen |= valid_o;
        end
        check("idle_no_valid", {63'd0, seen}, 64'd0);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Back-to-back strobes: results come out on consecutive cycles in order.
        tap_i = vecs[0].tap; sample_i = 1'b1; tick();
        tap_i = vecs[7].tap; tick();
        tap_i = vecs[2].tap; tick();
        sample_i = 1'b0; tap_i = '0;
        tick();
        check("b2b_0", {56'd0, valid_o, code_o}, {56'd0, 1'b1, 7'd16});
        tick();
        check("b2b_1", {56'd0, valid_o, code_o}, {56'd0, 1'b1, 7'd8});
        check("b2b_nodrop", {63'd0, drop_o}, 64'd0);
        tick();
        check("b2b_2", {55'd0, valid_o, sat_o, code_o}, {55'd0, 1'b1, 1'b1, 7'd64});
        tick();
        check("b2b_end", {63'd0, valid_o}, 64'd0);

        // Back-pressure: second result is discarded, first one held.
        ready_i = 1'b0;
        tap_i = vecs[0].tap; sample_i = 1'b1; tick();
        tap_i = vecs[7].tap; tick();
        sample_i = 1'b0; tap_i = '0;
        tick();
        tick();
        check("bp_hold", {55'd0, valid_o, drop_o, code_o}, {55'd0, 1'b1, 1'b0, 7'd16});
        tick();
        check("bp_drop", {55'd0, valid_o, drop_o, code_o}, {55'd0, 1'b1, 1'b1, 7'd16});
        check("bp_dcnt", {56'd0, drop_cnt_o}, 64'd1);
        tick();
        check("bp_pulse", {55'd0, valid_o, drop_o, code_o}, {55'd0, 1'b1, 1'b0, 7'd16});
        ready_i = 1'b1;
        tick();
        check("bp_xfer", {63'd0, valid_o}, 64'd0);
        check("bp_dcnt2", {56'd0, drop_cnt_o}, 64'd1);

        // Reset mid-flight: strobes before and during reset never surface.
        tap_i = vecs[0].tap; sample_i = 1'b1; tick();
        rst_n = 1'b0; tick();
        rst_n = 1'b1; sample_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen |= valid_o;
        end
        check("midrst_no_valid", {63'd0, seen}, 64'd0);
        check("midrst_dcnt", {56'd0, drop_cnt_o}, 64'd0);
        run_vec(10, vecs[1]);

        // Force 301 drops; counter must stop at 255.
        ready_i = 1'b0; tap_i = vecs[0].tap; sample_i = 1'b1;
        for (int i = 0; i < 302; i++) tick();
        sample_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("dcnt_sat", {56'd0, drop_cnt_o}, 64'd255);
        check("dcnt_hold", {56'd0, valid_o, code_o}, {56'd0, 1'b1, 7'd16});
        ready_i = 1'b1;
        tick();
        check("dcnt_final", {55'd0, valid_o, drop_cnt_o}, {55'd0, 1'b0, 8'd255});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
